// File: rtl/sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package sub_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // One full-subtractor bit: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
    logic diff;
    logic bout;
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    return {bout, diff};
  endfunction

endpackage

// File: rtl/nibble_sub.sv
// 4-bit ripple-borrow subtractor: d = a - b - bin, bout = borrow from bit 3.
module nibble_sub
  import sub_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic br1, br2, br3;

  assign {br1,  d[0]} = full_sub(a[0], b[0], bin);
  assign {br2,  d[1]} = full_sub(a[1], b[1], br1);
  assign {br3,  d[2]} = full_sub(a[2], b[2], br2);
  assign {bout, d[3]} = full_sub(a[3], b[3], br3);

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Serial A-B, one nibble per clock LSB first, with registered borrow and overflow flags.
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             borrow_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NIB = WIDTH / NIBBLE_W;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, d_q;
  logic             brw_q, bo_q, ov_q;

  logic [3:0]       nib_d;
  logic             nib_bout;
  logic             last;
  logic [WIDTH-1:0] acc_next;

  // Operands are shifted right each step, so the current nibble is always bits [3:0].
  nibble_sub u_nibble_sub (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .bin  (brw_q),
    .d    (nib_d),
    .bout (nib_bout)
  );

  assign last     = (cnt_q == CW'(NIB - 1));
  assign acc_next = WIDTH'({nib_d, acc_q} >> NIBBLE_W);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      brw_q <= 1'b0;
      d_q   <= '0;
      bo_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            acc_q <= '0;
            brw_q <= 1'b0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          a_q   <= a_q >> NIBBLE_W;
          b_q   <= b_q >> NIBBLE_W;
          acc_q <= acc_next;
          brw_q <= nib_bout;
          cnt_q <= cnt_q + CW'(1);
          // On the last step a_q/b_q[3] are the original operand sign bits.
          if (last) begin
            d_q  <= acc_next;
            bo_q <= nib_bout;
            ov_q <= (a_q[3] != b_q[3]) && (nib_d[3] != a_q[3]);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    D          = d_q;
    borrow_out = bo_q;
    overflow   = ov_q;
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor at WIDTH=16.
module tb_nibble_serial_subtractor;

  localparam int unsigned W = 16;

  logic         Clk;
  logic         Reset_n;
  logic         start;
  logic [W-1:0] A, B;
  logic [W-1:0] D;
  logic         borrow_out, overflow, busy, done;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .start      (start),
    .A          (A),
    .B          (B),
    .D          (D),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int unsigned  edge_no;
  } exp_t;

  exp_t         sb[$];
  int unsigned  n_checks = 0;
  int unsigned  n_pass   = 0;
  int unsigned  cyc      = 0;
  logic [W-1:0] hold_d   = '0;
  logic         hold_bo  = 1'b0;
  logic         hold_ov  = 1'b0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int unsigned k);
    exp_t e;
    e.d       = a - b;
    e.bo      = (a < b);
    e.ov      = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
    e.edge_no = k + W / 4;
    return e;
  endfunction

  // Result checker; outputs must hold their last value whenever done is low.
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("D",          32'(D),          32'(e.d));
          check("borrow_out", 32'(borrow_out), 32'(e.bo));
          check("overflow",   32'(overflow),   32'(e.ov));
          check("done_edge",  cyc,             e.edge_no);
          check("busy_in_done", 32'(busy),     32'd1);
          hold_d  = e.d;
          hold_bo = e.bo;
          hold_ov = e.ov;
        end
      end else begin
        check("D_hold",  32'(D),          32'(hold_d));
        check("bo_hold", 32'(borrow_out), 32'(hold_bo));
        check("ov_hold", 32'(overflow),   32'(hold_ov));
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned n;
    n = 0;
    @(negedge Clk);
    while (busy && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge Clk);
    #1;
    sb.push_back(model(a, b, cyc));
    start = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    start   = 1'b0;
    A       = '0;
    B       = '0;
    #23;
    check("rst_D",    32'(D),          32'd0);
    check("rst_bo",   32'(borrow_out), 32'd0);
    check("rst_ov",   32'(overflow),   32'd0);
    check("rst_busy", 32'(busy),       32'd0);
    check("rst_done", 32'(done),       32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    issue(16'h1234, 16'h0234); drain();
    issue(16'h1000, 16'h0001); drain();
    issue(16'h0000, 16'h0001); drain();
    issue(16'h8000, 16'h0001); drain();
    issue(16'h7FFF, 16'hFFFF); drain();
    issue(16'h0000, 16'h0000); drain();
    issue(16'hFFFF, 16'hFFFF); drain();
    issue(16'h8000, 16'h8000); drain();

    // Start held high from k+2 through the DONE edge with changing operands
    issue(16'h1234, 16'h0234);
    @(posedge Clk);
    #1;
    start = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      A = 16'(($urandom));
      B = 16'(($urandom));
      @(posedge Clk);
      #1;
    end
    start = 1'b0;
    drain();
    @(negedge Clk);
    check("idle_after_done", 32'(busy), 32'd0);

    // Reset two edges into an operation aborts it with no done pulse
    issue(16'hABCD, 16'h0123);
    void'(sb.pop_back());
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    hold_d  = '0;
    hold_bo = 1'b0;
    hold_ov = 1'b0;
    #1;
    check("abort_D",    32'(D),          32'd0);
    check("abort_bo",   32'(borrow_out), 32'd0);
    check("abort_ov",   32'(overflow),   32'd0);
    check("abort_busy", 32'(busy),       32'd0);
    check("abort_done", 32'(done),       32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (6) @(negedge Clk);
    issue(16'h0F0F, 16'hF0F0); drain();

    for (int unsigned i = 0; i < 20; i++) begin
      issue(16'($urandom), 16'($urandom));
      drain();
    end

    repeat (3) @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
